// File: rtl/riscv_icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package riscv_icache_pkg;

   localparam int XLEN = 32;

   // Controller states: lookup answers hits, refill streams a line in, resp
   // returns the word captured during the refill.
   typedef enum logic [1:0] {
      ICACHE_IDLE   = 2'd0,
      ICACHE_LOOKUP = 2'd1,
      ICACHE_REFILL = 2'd2,
      ICACHE_RESP   = 2'd3
   } icache_state_e;

endpackage

// File: rtl/riscv_icache_if.sv
// Fetch-side and memory-side handshake bundle of the instruction cache.
// The slave modport is the cache's view; master is the view of the
// environment around it (fetch unit plus instruction memory).
interface riscv_icache_if;

   logic        icache_rd;
   logic [31:0] icache_pc;
   logic        icache_flush;
   logic        icache_accept;
   logic        icache_valid;
   logic [31:0] icache_inst;
   logic        icache_error;

   logic        mem_rd;
   logic [31:0] mem_addr;
   logic        mem_accept;
   logic        mem_valid;
   logic [31:0] mem_data;
   logic        mem_error;

   modport slave (
      input  icache_rd, icache_pc, icache_flush,
      output icache_accept, icache_valid, icache_inst, icache_error,
      output mem_rd, mem_addr,
      input  mem_accept, mem_valid, mem_data, mem_error
   );

   modport master (
      output icache_rd, icache_pc, icache_flush,
      input  icache_accept, icache_valid, icache_inst, icache_error,
      input  mem_rd, mem_addr,
      output mem_accept, mem_valid, mem_data, mem_error
   );

endinterface

// File: rtl/riscv_icache_ram.sv
// Synchronous single-port RAM with a one-cycle registered read.
// Used for both the tag array and the instruction data array.
module riscv_icache_ram #(
   parameter int DW = 32,
   parameter int AW = 6
) (
   input  logic          clk_i,
   input  logic [AW-1:0] addr,
   input  logic          we,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [0:(1<<AW)-1];

   // Write on request; the addressed word is always read out one cycle later.
   always_ff @(posedge clk_i) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/riscv_icache.sv
// Direct-mapped read-only instruction cache between the fetch unit and the
// instruction memory bus. Hits respond one cycle after acceptance; misses
// refill the whole line one word at a time, then respond.
// Optional feature: define RISCV_ICACHE_PERF_EN to build hit/miss counters.
module riscv_icache
   import riscv_icache_pkg::*;
#(
   parameter int NUM_LINES  = 64,
   parameter int LINE_WORDS = 4
) (
   input  logic           clk_i,
   input  logic           rst_n_i,
   riscv_icache_if.slave  bus,
   output logic [31:0]    perf_hit_o,
   output logic [31:0]    perf_miss_o
);

   localparam int OW = $clog2(LINE_WORDS);
   localparam int IW = $clog2(NUM_LINES);
   localparam int TW = XLEN - IW - OW - 2;

   icache_state_e          state_q, state_d;
   logic [XLEN-1:2]        pc_q;
   logic [NUM_LINES-1:0]   valid_q;
   logic [OW-1:0]          beat_q;
   logic                   mem_rd_q;
   logic                   wait_q;
   logic                   err_q;
   logic                   flush_pending_q;
   logic [31:0]            inst_q;

   logic [TW-1:0]          req_tag;
   logic [IW-1:0]          req_idx;
   logic [OW-1:0]          req_off;
   logic [IW-1:0]          new_idx;
   logic [OW-1:0]          new_off;

   logic [IW-1:0]          tag_addr;
   logic                   tag_we;
   logic [TW-1:0]          tag_rdata;
   logic [IW+OW-1:0]       data_addr;
   logic                   data_we;
   logic [31:0]            data_rdata;

   logic                   hit;
   logic                   take;
   logic                   beat_done;
   logic                   last_beat;
   logic                   accept;
   logic                   resp_valid;
   logic [31:0]            resp_inst;
   logic                   resp_error;

   assign req_tag   = pc_q[XLEN-1:IW+OW+2];
   assign req_idx   = pc_q[IW+OW+1:OW+2];
   assign req_off   = pc_q[OW+1:2];
   assign new_idx   = bus.icache_pc[IW+OW+1:OW+2];
   assign new_off   = bus.icache_pc[OW+1:2];

   assign hit       = (tag_rdata == req_tag) && valid_q[req_idx];
   assign take      = bus.icache_rd && accept;
   assign last_beat = (beat_q == OW'(LINE_WORDS - 1));
   assign beat_done = (state_q == ICACHE_REFILL) && bus.mem_valid &&
                      (wait_q || (mem_rd_q && bus.mem_accept));

   // The tag port is idle during a refill, so the new tag is written there;
   // the line only becomes usable once its valid bit is set in RESP.
   assign tag_addr  = take ? new_idx : req_idx;
   assign tag_we    = (state_q == ICACHE_REFILL);
   assign data_addr = take ? {new_idx, new_off} : {req_idx, beat_q};
   assign data_we   = beat_done;

   riscv_icache_ram #(.DW(TW), .AW(IW)) u_tag_ram (
      .clk_i (clk_i),
      .addr  (tag_addr),
      .we    (tag_we),
      .wdata (req_tag),
      .rdata (tag_rdata)
   );

   riscv_icache_ram #(.DW(32), .AW(IW+OW)) u_data_ram (
      .clk_i (clk_i),
      .addr  (data_addr),
      .we    (data_we),
      .wdata (bus.mem_data),
      .rdata (data_rdata)
   );

   // Next-state and response outputs of the cache controller.
   always_comb begin
      state_d    = state_q;
      accept     = 1'b0;
      resp_valid = 1'b0;
      resp_inst  = '0;
      resp_error = 1'b0;
      case (state_q)
         ICACHE_IDLE: begin
            accept = 1'b1;
            if (bus.icache_rd) begin
               state_d = ICACHE_LOOKUP;
            end
         end
         ICACHE_LOOKUP: begin
            if (hit) begin
               accept     = 1'b1;
               resp_valid = 1'b1;
               resp_inst  = data_rdata;
               state_d    = bus.icache_rd ? ICACHE_LOOKUP : ICACHE_IDLE;
            end else begin
               state_d    = ICACHE_REFILL;
            end
         end
         ICACHE_REFILL: begin
            if (beat_done && last_beat) begin
               state_d = ICACHE_RESP;
            end
         end
         ICACHE_RESP: begin
            accept     = 1'b1;
            resp_valid = 1'b1;
            resp_inst  = inst_q;
            resp_error = err_q;
            state_d    = bus.icache_rd ? ICACHE_LOOKUP : ICACHE_IDLE;
         end
         default: begin
            state_d = ICACHE_IDLE;
         end
      endcase
   end

   assign bus.icache_accept = accept;
   assign bus.icache_valid  = resp_valid;
   assign bus.icache_inst   = resp_inst;
   assign bus.icache_error  = resp_error;
   assign bus.mem_rd        = mem_rd_q;
   assign bus.mem_addr      = {pc_q[XLEN-1:OW+2], beat_q, 2'b00};

   // Controller state register.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ICACHE_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Capture the fetch address of every accepted request.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         pc_q <= '0;
      end else if (take) begin
         pc_q <= bus.icache_pc[XLEN-1:2];
      end
   end

   // Refill sequencing: one read outstanding, every beat consumed, errors sticky.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         mem_rd_q <= 1'b0;
         wait_q   <= 1'b0;
         beat_q   <= '0;
         err_q    <= 1'b0;
         inst_q   <= '0;
      end else if (state_q == ICACHE_LOOKUP && !hit) begin
         mem_rd_q <= 1'b1;
         wait_q   <= 1'b0;
         beat_q   <= '0;
         err_q    <= 1'b0;
      end else if (state_q == ICACHE_REFILL) begin
         if (mem_rd_q && bus.mem_accept) begin
            mem_rd_q <= 1'b0;
            wait_q   <= 1'b1;
         end
         if (beat_done) begin
            wait_q <= 1'b0;
            if (bus.mem_error) begin
               err_q <= 1'b1;
            end
            if (beat_q == req_off) begin
               inst_q <= bus.mem_data;
            end
            if (!last_beat) begin
               beat_q   <= beat_q + 1'b1;
               mem_rd_q <= 1'b1;
            end
         end
      end
   end

   // Line valid bits: flush wins, a refilled line is dropped until it
   // completes cleanly without a flush having been seen along the way.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         valid_q <= '0;
      end else if (bus.icache_flush) begin
         valid_q <= '0;
      end else if (state_q == ICACHE_LOOKUP && !hit) begin
         valid_q[req_idx] <= 1'b0;
      end else if (state_q == ICACHE_RESP && !err_q && !flush_pending_q) begin
         valid_q[req_idx] <= 1'b1;
      end
   end

   // Remember a flush that lands while a line is being brought in.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         flush_pending_q <= 1'b0;
      end else if (state_q == ICACHE_LOOKUP && !hit) begin
         flush_pending_q <= bus.icache_flush;
      end else if (state_q == ICACHE_REFILL && bus.icache_flush) begin
         flush_pending_q <= 1'b1;
      end else if (state_q == ICACHE_RESP) begin
         flush_pending_q <= 1'b0;
      end
   end

`ifdef RISCV_ICACHE_PERF_EN
   logic [31:0] hit_cnt_q;
   logic [31:0] miss_cnt_q;

   // Count every lookup outcome; counters wrap and clear on reset only.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else if (state_q == ICACHE_LOOKUP) begin
         if (hit) begin
            hit_cnt_q <= hit_cnt_q + 32'd1;
         end else begin
            miss_cnt_q <= miss_cnt_q + 32'd1;
         end
      end
   end

   assign perf_hit_o  = hit_cnt_q;
   assign perf_miss_o = miss_cnt_q;
`else
   assign perf_hit_o  = '0;
   assign perf_miss_o = '0;
`endif

endmodule
